// File: rtl/led_matrix_scan.sv
// 4x4 LED matrix scanner: column-multiplexed cathode enables with dead-time blanking,
// global PWM brightness and a one-deep pending frame buffer loaded by valid/ready.
module led_matrix_scan #(
    parameter int unsigned SCAN_DIV    = 12000,
    parameter int unsigned DEAD_CYCLES = 48,
    parameter int unsigned PWM_BITS    = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [15:0]         frame_in,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic [PWM_BITS-1:0] brightness,
    output logic [3:0]          kled_tri,
    output logic [3:0]          aled,
    output logic                frame_sync
);

    localparam int unsigned CNT_MAX = (SCAN_DIV > DEAD_CYCLES) ? SCAN_DIV : DEAD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                run_q, run_d;
    logic [15:0]         active_q, active_d;
    logic [15:0]         pend_q, pend_d;
    logic                pend_full_q, pend_full_d;
    logic [PWM_BITS-1:0] bright_q, bright_d;
    logic [3:0]          kled_q, kled_d;
    logic [3:0]          aled_q, aled_d;
    logic                sync_q, sync_d;
    logic [3:0]          row_d;
    logic                pwm_on_d;

    // Next-state logic; outputs are computed for the cycle being entered so they register cleanly.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        cnt_d       = cnt_q + 1'b1;
        pwm_d       = pwm_q + 1'b1;
        run_d       = 1'b1;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        bright_d    = bright_q;
        kled_d      = 4'b0000;
        aled_d      = 4'b0000;
        sync_d      = 1'b0;
        row_d       = 4'b0000;
        pwm_on_d    = 1'b0;

        // run_q low means the next cycle is the very first frame start after reset.
        if (!run_q) begin
            state_d = ST_BLANK;
            col_d   = 2'd0;
            cnt_d   = '0;
            pwm_d   = '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == DEAD_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        pwm_d   = '0;
                    end
                end
                ST_ON: begin
                    if (cnt_q == SCAN_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        col_d   = col_q + 2'd1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                end
            endcase
        end

        sync_d = (state_d == ST_BLANK) && (col_d == 2'd0) && (cnt_d == '0);

        // Swap reads the pre-edge pending word; a word accepted on the same edge stays pending.
        if (sync_d) begin
            bright_d = brightness;
            if (pend_full_q) begin
                active_d    = pend_q;
                pend_full_d = 1'b0;
            end
        end
        if (frame_valid && !pend_full_q) begin
            pend_d      = frame_in;
            pend_full_d = 1'b1;
        end

        row_d    = active_q[{col_d, 2'b00} +: 4];
        pwm_on_d = (bright_q == '1) || (pwm_d < bright_q);
        if (state_d == ST_ON) begin
            kled_d = 4'b0001 << col_d;
            aled_d = pwm_on_d ? row_d : 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_BLANK;
            col_q       <= 2'd0;
            cnt_q       <= '0;
            pwm_q       <= '0;
            run_q       <= 1'b0;
            active_q    <= 16'h0000;
            pend_q      <= 16'h0000;
            pend_full_q <= 1'b0;
            bright_q    <= '0;
            kled_q      <= 4'b0000;
            aled_q      <= 4'b0000;
            sync_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            pwm_q       <= pwm_d;
            run_q       <= run_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            bright_q    <= bright_d;
            kled_q      <= kled_d;
            aled_q      <= aled_d;
            sync_q      <= sync_d;
        end
    end

    assign frame_ready = ~pend_full_q;
    assign kled_tri    = kled_q;
    assign aled        = aled_q;
    assign frame_sync  = sync_q;

endmodule
